// File: rtl/sdram_init_checker.sv
// SDRAM power-up sequence monitor: checks PRE-ALL -> REF xN -> MRS ordering and gaps,
// latches the mode word, reports device-ready and the first protocol error.
module sdram_init_checker #(
  parameter int T_POWERUP = 4000,
  parameter int T_RP      = 1,
  parameter int T_RFC     = 2,
  parameter int T_MRD     = 2,
  parameter int REF_NUM   = 2
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        cke,
  input  logic [3:0]  cmd,
  input  logic [12:0] mod_config,
  input  logic        ctrl_init_done,
  output logic        model_ready,
  output logic [2:0]  cas_lat,
  output logic [2:0]  burst_len,
  output logic        burst_type,
  output logic        wr_single,
  output logic        init_err,
  output logic [2:0]  err_code
);

  localparam int PW = $clog2(T_POWERUP + 1);
  localparam int RW = (REF_NUM > 1) ? $clog2(REF_NUM + 1) : 1;
  localparam logic [PW-1:0] PWR_MAX = PW'(T_POWERUP);
  localparam logic [RW-1:0] REF_MAX = RW'(REF_NUM);
  localparam logic [7:0]    K_RP    = 8'(T_RP);
  localparam logic [7:0]    K_RFC   = 8'(T_RFC);
  localparam logic [7:0]    K_MRD   = 8'(T_MRD);

  typedef enum logic [2:0] {
    S_PWRUP, S_TRP, S_TRFC, S_TMRD, S_READY, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pwr_cnt_q, pwr_cnt_d;
  logic [7:0]      gap_q, gap_d;
  logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
  logic            model_ready_q, model_ready_d;
  logic            init_err_q, init_err_d;
  logic [2:0]      err_code_q, err_code_d;
  logic [2:0]      cas_lat_q, cas_lat_d;
  logic [2:0]      burst_len_q, burst_len_d;
  logic            burst_type_q, burst_type_d;
  logic            wr_single_q, wr_single_d;

  logic is_nop, is_pre, is_ref, is_mrs, cmd_v, mode_bad, latch;
  logic e6, et, e1, e2, e7;
  logic [2:0] t_code, code;
  logic unused_addr;

  assign unused_addr = ^{mod_config[12:11], mod_config[8:7]};

  assign is_nop   = cmd[3] | (cmd == 4'b0111);
  assign is_pre   = (cmd == 4'b0010);
  assign is_ref   = (cmd == 4'b0001);
  assign is_mrs   = (cmd == 4'b0000);
  assign cmd_v    = cke & ~is_nop;
  assign mode_bad = ((mod_config[6:4] != 3'd2) && (mod_config[6:4] != 3'd3)) ||
                    (mod_config[2:0] == 3'd4) || (mod_config[2:0] == 3'd5) ||
                    (mod_config[2:0] == 3'd6);

  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    ref_cnt_d = ref_cnt_q;
    latch     = 1'b0;
    e6        = 1'b0;
    et        = 1'b0;
    e1        = 1'b0;
    e2        = 1'b0;
    e7        = 1'b0;
    t_code    = 3'd0;
    code      = 3'd0;

    // gap_q is the k a command would see on this edge; cke=0 edges do not advance it
    if (cmd_v)                        gap_d = 8'd1;
    else if (cke && gap_q != 8'hFF)   gap_d = gap_q + 8'd1;
    else                              gap_d = gap_q;

    case (state_q)
      S_PWRUP: begin
        if (cke && is_nop && pwr_cnt_q != PWR_MAX) pwr_cnt_d = pwr_cnt_q + PW'(1);
        if (cmd_v) begin
          if (pwr_cnt_q != PWR_MAX)          e1 = 1'b1;
          else if (is_pre && mod_config[10]) state_d = S_TRP;
          else                               e2 = 1'b1;
        end
      end
      S_TRP: begin
        if (cmd_v) begin
          if (gap_q < K_RP) begin
            et = 1'b1; t_code = 3'd3;
          end else if (is_ref) begin
            state_d   = S_TRFC;
            ref_cnt_d = RW'(1);
          end else e2 = 1'b1;
        end
      end
      S_TRFC: begin
        if (cmd_v) begin
          if (gap_q < K_RFC) begin
            et = 1'b1; t_code = 3'd4;
          end else if (is_ref) begin
            if (ref_cnt_q != REF_MAX) ref_cnt_d = ref_cnt_q + RW'(1);
          end else if (is_mrs && ref_cnt_q >= REF_MAX) begin
            if (mode_bad) e7 = 1'b1;
            else begin
              latch   = 1'b1;
              state_d = S_TMRD;
            end
          end else e2 = 1'b1;
        end
      end
      S_TMRD: begin
        if (cmd_v && gap_q < K_MRD) begin
          et = 1'b1; t_code = 3'd5;
        end else if (gap_q >= K_MRD) state_d = S_READY;
      end
      S_READY: begin
        if (cmd_v && is_mrs) begin
          if (mode_bad) e7 = 1'b1;
          else          latch = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_q != S_READY && state_q != S_ERR && ctrl_init_done) e2 = 1'b1;
    if (!cke && state_q != S_ERR && (state_q != S_PWRUP || pwr_cnt_q == PWR_MAX)) e6 = 1'b1;

    if (e6)      code = 3'd6;
    else if (et) code = t_code;
    else if (e1) code = 3'd1;
    else if (e2) code = 3'd2;
    else if (e7) code = 3'd7;

    if (code != 3'd0) begin
      state_d = S_ERR;
      latch   = 1'b0;
    end

    model_ready_d = (state_d == S_READY);
    init_err_d    = (state_d == S_ERR);
    err_code_d    = (state_q != S_ERR && code != 3'd0) ? code : err_code_q;
    cas_lat_d     = latch ? mod_config[6:4] : cas_lat_q;
    burst_len_d   = latch ? mod_config[2:0] : burst_len_q;
    burst_type_d  = latch ? mod_config[3]   : burst_type_q;
    wr_single_d   = latch ? mod_config[9]   : wr_single_q;
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q       <= S_PWRUP;
      pwr_cnt_q     <= '0;
      gap_q         <= '0;
      ref_cnt_q     <= '0;
      model_ready_q <= 1'b0;
      init_err_q    <= 1'b0;
      err_code_q    <= 3'd0;
      cas_lat_q     <= 3'd0;
      burst_len_q   <= 3'd0;
      burst_type_q  <= 1'b0;
      wr_single_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwr_cnt_q     <= pwr_cnt_d;
      gap_q         <= gap_d;
      ref_cnt_q     <= ref_cnt_d;
      model_ready_q <= model_ready_d;
      init_err_q    <= init_err_d;
      err_code_q    <= err_code_d;
      cas_lat_q     <= cas_lat_d;
      burst_len_q   <= burst_len_d;
      burst_type_q  <= burst_type_d;
      wr_single_q   <= wr_single_d;
    end
  end

  assign model_ready = model_ready_q;
  assign init_err    = init_err_q;
  assign err_code    = err_code_q;
  assign cas_lat     = cas_lat_q;
  assign burst_len   = burst_len_q;
  assign burst_type  = burst_type_q;
  assign wr_single   = wr_single_q;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Bench for sdram_init_checker: table of per-edge vectors plus hand-written corner sequences,
// expected outputs go through a queue and are compared on the falling edge after each sample.
module tb_sdram_init_checker;

  localparam int TPU = 8;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [12:0] A10 = 13'h400;
  localparam logic [12:0] Z   = 13'd0;

  logic        sclk = 1'b0;
  logic        srst, cke, ctrl_init_done;
  logic [3:0]  cmd;
  logic [12:0] mod_config;
  logic        model_ready, burst_type, wr_single, init_err;
  logic [2:0]  cas_lat, burst_len, err_code;

  sdram_init_checker #(.T_POWERUP(TPU)) dut (
    .sclk(sclk), .srst(srst), .cke(cke), .cmd(cmd), .mod_config(mod_config),
    .ctrl_init_done(ctrl_init_done), .model_ready(model_ready), .cas_lat(cas_lat),
    .burst_len(burst_len), .burst_type(burst_type), .wr_single(wr_single),
    .init_err(init_err), .err_code(err_code)
  );

  // clock / reset block
  always #25 sclk = ~sclk;

  initial begin
    #(50 * 20000);
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    int          tag;
    logic        srst;
    logic        cke;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        done;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          step_idx = 0;

  // packed expectation: {ready, init_err, err_code, cas_lat, burst_len, burst_type, wr_single}
  function automatic logic [12:0] pk(input logic r, input logic e, input logic [2:0] c,
                                     input logic [2:0] cas, input logic [2:0] bl,
                                     input logic bt, input logic ws);
    return {r, e, c, cas, bl, bt, ws};
  endfunction

  function automatic logic [3:0] rnd_nop();
    logic [2:0] lo;
    lo = 3'($urandom_range(0, 7));
    return ($urandom_range(0, 1) == 0) ? NOP : {1'b1, lo};
  endfunction

  function automatic logic [12:0] rnd_addr();
    return 13'($urandom_range(0, 8191));
  endfunction

  function automatic void add(input int tag, input logic s, input logic k, input logic [3:0] c,
                              input logic [12:0] a, input logic d, input logic [12:0] x);
    vec_t v;
    v.tag = tag; v.srst = s; v.cke = k; v.cmd = c; v.addr = a; v.done = d; v.exp = x;
    vecs.push_back(v);
  endfunction

  function automatic void add_nops(input int tag, input int n, input logic [12:0] x);
    for (int i = 0; i < n; i++) add(tag, 1'b0, 1'b1, rnd_nop(), rnd_addr(), 1'b0, x);
  endfunction

  function automatic void add_rst(input int tag);
    for (int i = 0; i < 2; i++) add(tag, 1'b1, 1'b1, NOP, Z, 1'b0, Z);
  endfunction

  function automatic void add_to_trfc(input int tag);
    add_nops(tag, TPU, Z);
    add(tag, 1'b0, 1'b1, PRE, A10, 1'b0, Z);
    add_nops(tag, 1, Z);
    add(tag, 1'b0, 1'b1, REF, Z, 1'b0, Z);
  endfunction

  function automatic void add_legal(input int tag);
    add_to_trfc(tag);
    add_nops(tag, 2, Z);
    add(tag, 1'b0, 1'b1, REF, Z, 1'b0, Z);
    add_nops(tag, 2, Z);
    add(tag, 1'b0, 1'b1, MRS, 13'h032, 1'b0, pk(0, 0, 0, 3, 2, 0, 0));
    add_nops(tag, 1, pk(0, 0, 0, 3, 2, 0, 0));
    add_nops(tag, 1, pk(1, 0, 0, 3, 2, 0, 0));
  endfunction

  // driver + scoreboard: drive at negedge, DUT samples at posedge, compare at next negedge
  task automatic step(input int tag, input logic s, input logic k, input logic [3:0] c,
                      input logic [12:0] a, input logic d, input logic [12:0] x);
    logic [12:0] got, want;
    srst = s; cke = k; cmd = c; mod_config = a; ctrl_init_done = d;
    exp_q.push_back(x);
    @(posedge sclk);
    @(negedge sclk);
    got  = {model_ready, init_err, err_code, cas_lat, burst_len, burst_type, wr_single};
    want = exp_q.pop_front();
    total_cnt++;
    step_idx++;
    if (got === want) pass_cnt++;
    else $display("FAIL test%0d step%0d: got ready=%b err=%b code=%0d cas=%0d bl=%0d bt=%b ws=%b, expected ready=%b err=%b code=%0d cas=%0d bl=%0d bt=%b ws=%b",
                  tag, step_idx, got[12], got[11], got[10:8], got[7:5], got[4:2], got[1], got[0],
                  want[12], want[11], want[10:8], want[7:5], want[4:2], want[1], want[0]);
  endtask

  task automatic run_nops(input int tag, input int n, input logic [12:0] x);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, rnd_nop(), rnd_addr(), 1'b0, x);
  endtask

  task automatic run_rst(input int tag);
    for (int i = 0; i < 2; i++) step(tag, 1'b1, 1'b1, NOP, Z, 1'b0, Z);
  endtask

  task automatic run_to_trfc(input int tag);
    run_nops(tag, TPU, Z);
    step(tag, 1'b0, 1'b1, PRE, A10, 1'b0, Z);
    run_nops(tag, 1, Z);
    step(tag, 1'b0, 1'b1, REF, Z, 1'b0, Z);
  endtask

  initial begin
    srst = 1'b1; cke = 1'b1; cmd = NOP; mod_config = Z; ctrl_init_done = 1'b0;

    // 1: legal sequence, done in READY, re-latch in READY, reserved re-latch
    add_rst(1);
    add_legal(1);
    add(1, 1'b0, 1'b1, NOP, Z, 1'b1, pk(1, 0, 0, 3, 2, 0, 0));
    add(1, 1'b0, 1'b1, MRS, 13'h23A, 1'b0, pk(1, 0, 0, 3, 2, 1, 1));
    add(1, 1'b0, 1'b1, MRS, 13'h054, 1'b0, pk(0, 1, 7, 3, 2, 1, 1));
    add_nops(1, 2, pk(0, 1, 7, 3, 2, 1, 1));
    // 2: command during power-up
    add_rst(2);
    add_nops(2, 3, Z);
    add(2, 1'b0, 1'b1, REF, Z, 1'b0, pk(0, 1, 1, 0, 0, 0, 0));
    add_nops(2, 2, pk(0, 1, 1, 0, 0, 0, 0));
    // 3: REF too close to REF, later legal traffic keeps code 4
    add_rst(3);
    add_to_trfc(3);
    add(3, 1'b0, 1'b1, REF, Z, 1'b0, pk(0, 1, 4, 0, 0, 0, 0));
    add_nops(3, 1, pk(0, 1, 4, 0, 0, 0, 0));
    add(3, 1'b0, 1'b1, REF, Z, 1'b0, pk(0, 1, 4, 0, 0, 0, 0));
    add_nops(3, 2, pk(0, 1, 4, 0, 0, 0, 0));
    add(3, 1'b0, 1'b1, MRS, 13'h032, 1'b0, pk(0, 1, 4, 0, 0, 0, 0));
    // 4a: MRS after one REF; 4b: reserved CAS latency
    add_rst(4);
    add_to_trfc(4);
    add_nops(4, 2, Z);
    add(4, 1'b0, 1'b1, MRS, 13'h032, 1'b0, pk(0, 1, 2, 0, 0, 0, 0));
    add_rst(4);
    add_to_trfc(4);
    add_nops(4, 2, Z);
    add(4, 1'b0, 1'b1, REF, Z, 1'b0, Z);
    add_nops(4, 2, Z);
    add(4, 1'b0, 1'b1, MRS, 13'h052, 1'b0, pk(0, 1, 7, 0, 0, 0, 0));
    // 5a: cke drop after PRE; 5b: premature init_done in TRFC
    add_rst(5);
    add_nops(5, TPU, Z);
    add(5, 1'b0, 1'b1, PRE, A10, 1'b0, Z);
    add(5, 1'b0, 1'b0, NOP, Z, 1'b0, pk(0, 1, 6, 0, 0, 0, 0));
    add_rst(5);
    add_to_trfc(5);
    add(5, 1'b0, 1'b1, NOP, Z, 1'b1, pk(0, 1, 2, 0, 0, 0, 0));
    // 6: reset pulse mid-TRFC then full legal sequence
    add_rst(6);
    add_to_trfc(6);
    add_nops(6, 1, Z);
    add(6, 1'b1, 1'b1, NOP, Z, 1'b0, Z);
    add_legal(6);

    @(negedge sclk);
    foreach (vecs[i])
      step(vecs[i].tag, vecs[i].srst, vecs[i].cke, vecs[i].cmd, vecs[i].addr, vecs[i].done, vecs[i].exp);

    // 11: cke=0 during power-up does not count toward T_POWERUP
    run_rst(11);
    run_nops(11, 4, Z);
    for (int i = 0; i < 3; i++) step(11, 1'b0, 1'b0, NOP, Z, 1'b0, Z);
    run_nops(11, 3, Z);
    step(11, 1'b0, 1'b1, PRE, A10, 1'b0, pk(0, 1, 1, 0, 0, 0, 0));

    // 12: precharge without A10 after power-up
    run_rst(12);
    run_nops(12, TPU, Z);
    step(12, 1'b0, 1'b1, PRE, Z, 1'b0, pk(0, 1, 2, 0, 0, 0, 0));

    // 13: command too soon after MRS
    run_rst(13);
    run_to_trfc(13);
    run_nops(13, 2, Z);
    step(13, 1'b0, 1'b1, REF, Z, 1'b0, Z);
    run_nops(13, 2, Z);
    step(13, 1'b0, 1'b1, MRS, 13'h032, 1'b0, pk(0, 0, 0, 3, 2, 0, 0));
    step(13, 1'b0, 1'b1, REF, Z, 1'b0, pk(0, 1, 5, 3, 2, 0, 0));

    // 14: priority - timing beats order, cke drop beats order
    run_rst(14);
    run_to_trfc(14);
    step(14, 1'b0, 1'b1, REF, Z, 1'b1, pk(0, 1, 4, 0, 0, 0, 0));
    run_rst(14);
    run_nops(14, TPU, Z);
    step(14, 1'b0, 1'b0, NOP, Z, 1'b1, pk(0, 1, 6, 0, 0, 0, 0));

    // 15: gaps exactly at T_RFC are legal, MRS at k=T_RFC, READY at k=T_MRD
    run_rst(15);
    run_to_trfc(15);
    run_nops(15, 1, Z);
    step(15, 1'b0, 1'b1, REF, Z, 1'b0, Z);
    run_nops(15, 1, Z);
    step(15, 1'b0, 1'b1, MRS, 13'h032, 1'b0, pk(0, 0, 0, 3, 2, 0, 0));
    run_nops(15, 1, pk(0, 0, 0, 3, 2, 0, 0));
    run_nops(15, 1, pk(1, 0, 0, 3, 2, 0, 0));

    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: got %0d leftover, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
